// File: rtl/fc_pkg.sv
// Shared types and constants for the FC result packer slice.
package fc_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PACK = 1'b1
  } fc_state_e;

  localparam int unsigned FC_BYTE_W     = 8;
  localparam int unsigned FC_WORD_BYTES = 4;
  localparam int unsigned FC_MAX_NODES  = 128;

  function automatic logic [7:0] fc_relu(input logic signed [7:0] x);
    return x[7] ? 8'h00 : x;
  endfunction

endpackage

// File: rtl/fc_act_unit.sv
// Activation applied to each FC result byte before packing.
// FC_PACKER_RELU_EN selects fused ReLU; otherwise bytes pass through unchanged.
module fc_act_unit
  import fc_pkg::*;
(
  input  logic [FC_BYTE_W-1:0] x,
  output logic [FC_BYTE_W-1:0] y
);

  always_comb begin
`ifdef FC_PACKER_RELU_EN
    y = fc_relu(x);
`else
    y = x;
`endif
  end

endmodule

// File: rtl/fc_result_packer.sv
// Packs activated int8 FC results into little-endian SRAM words with byte strobes.
// Optional fused ReLU via FC_PACKER_RELU_EN (see fc_act_unit).
module fc_result_packer
  import fc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fc_valid_i,
  input  logic                      last_i,
  input  logic [7:0]                fc_result_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  output logic                      wr_en_o,
  output logic [ADDR_WIDTH-1:0]     wr_addr_o,
  output logic [8*WORD_BYTES-1:0]   wr_data_o,
  output logic [WORD_BYTES-1:0]     wr_strb_o,
  output logic                      done_o,
  output logic [7:0]                frame_len_o
);

  localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

  fc_state_e                   state_q, state_d;
  logic [1:0]                  lane_q, lane_d;
  logic [ADDR_WIDTH-1:0]       ptr_q, ptr_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [8*WORD_BYTES-1:0]     buf_q, buf_d;

  logic                        wr_en_d, done_d;
  logic [ADDR_WIDTH-1:0]       wr_addr_d;
  logic [8*WORD_BYTES-1:0]     wr_data_d;
  logic [WORD_BYTES-1:0]       wr_strb_d;
  logic [7:0]                  frame_len_d;

  logic [7:0]                  act_byte;
  logic [1:0]                  cur_lane;
  logic [ADDR_WIDTH-1:0]       cur_ptr;
  logic [7:0]                  cur_cnt;
  logic [8*WORD_BYTES-1:0]     cur_word;

  fc_act_unit u_act (
    .x (fc_result_i),
    .y (act_byte)
  );

  // The first byte of a frame takes pointer/count from the inputs directly,
  // so a frame can start in the same cycle the previous one is flushing.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_o;
    wr_data_d   = wr_data_o;
    wr_strb_d   = '0;
    done_d      = 1'b0;
    frame_len_d = frame_len_o;

    if (state_q == S_IDLE) begin
      cur_lane = '0;
      cur_ptr  = base_addr_i;
      cur_cnt  = 8'd1;
      cur_word = '0;
    end else begin
      cur_lane = lane_q;
      cur_ptr  = ptr_q;
      cur_cnt  = 8'(cnt_q + 8'd1);
      cur_word = buf_q;
    end
    cur_word[8*cur_lane +: 8] = act_byte;

    if (fc_valid_i) begin
      cnt_d = cur_cnt;
      if (cur_lane == LAST_LANE || last_i) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cur_ptr;
        wr_data_d = cur_word;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
          wr_strb_d[i] = (2'(i) <= cur_lane);
        end
        ptr_d  = cur_ptr + 1'b1;
        lane_d = '0;
        buf_d  = '0;
        if (last_i) begin
          done_d      = 1'b1;
          frame_len_d = cur_cnt;
          state_d     = S_IDLE;
        end else begin
          state_d = S_PACK;
        end
      end else begin
        buf_d   = cur_word;
        lane_d  = cur_lane + 2'd1;
        ptr_d   = cur_ptr;
        state_d = S_PACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      wr_strb_o   <= '0;
      done_o      <= 1'b0;
      frame_len_o <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      wr_en_o     <= wr_en_d;
      wr_addr_o   <= wr_addr_d;
      wr_data_o   <= wr_data_d;
      wr_strb_o   <= wr_strb_d;
      done_o      <= done_d;
      frame_len_o <= frame_len_d;
    end
  end

endmodule

// File: tb/tb_fc_result_packer.sv
// Randomized self-checking bench for fc_result_packer against a byte-queue reference model.
module tb_fc_result_packer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          fc_valid_i;
  logic          last_i;
  logic [7:0]    fc_result_i;
  logic [AW-1:0] base_addr_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [31:0]   wr_data_o;
  logic [3:0]    wr_strb_o;
  logic          done_o;
  logic [7:0]    frame_len_o;

  fc_result_packer #(.ADDR_WIDTH(AW), .WORD_BYTES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fc_valid_i  (fc_valid_i),
    .last_i      (last_i),
    .fc_result_i (fc_result_i),
    .base_addr_i (base_addr_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_strb_o   (wr_strb_o),
    .done_o      (done_o),
    .frame_len_o (frame_len_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes of the current word held in a queue.
  bit            in_frame;
  logic [7:0]    cur[$];
  int            cnt;
  logic [AW-1:0] ptr;
  logic          exp_en, exp_done;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_data;
  logic [3:0]    exp_strb;
  logic [7:0]    exp_len;

  function automatic logic [7:0] act(input logic [7:0] x);
`ifdef FC_PACKER_RELU_EN
    return ($signed(x) < 0) ? 8'h00 : x;
`else
    return x;
`endif
  endfunction

  task automatic check_all();
    chk("wr_en", wr_en_o, exp_en);
    chk("wr_addr", wr_addr_o, exp_addr);
    chk("wr_data", wr_data_o, exp_data);
    chk("wr_strb", wr_strb_o, exp_strb);
    chk("done", done_o, exp_done);
    chk("frame_len", frame_len_o, exp_len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fc_valid_i = 1'b0;
    last_i = 1'b0;
    in_frame = 0;
    cur.delete();
    cnt = 0;
    exp_en = 0; exp_done = 0; exp_addr = '0; exp_data = '0; exp_strb = '0; exp_len = '0;
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  task automatic cycle(input bit v, input bit l, input logic [7:0] b, input logic [AW-1:0] base);
    fc_valid_i = v;
    last_i = l;
    fc_result_i = b;
    base_addr_i = base;
    exp_en = 0;
    exp_strb = '0;
    exp_done = 0;
    if (v) begin
      if (!in_frame) begin
        in_frame = 1;
        ptr = base;
        cnt = 0;
        cur.delete();
      end
      cur.push_back(act(b));
      cnt++;
      if (cur.size() == 4 || l) begin
        exp_en = 1;
        exp_addr = ptr;
        exp_data = '0;
        foreach (cur[i]) begin
          exp_data[8*i +: 8] = cur[i];
          exp_strb[i] = 1'b1;
        end
        ptr = ptr + 1'b1;
        cur.delete();
        if (l) begin
          exp_done = 1;
          exp_len = 8'(cnt);
          in_frame = 0;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    fc_valid_i = 1'b0;
    last_i = 1'b0;
    fc_result_i = '0;
    base_addr_i = '0;
    do_reset();
    chk("reset_data", wr_data_o, 32'h0);

    // 8 bytes 01..08 at base 0x010
    for (int i = 1; i <= 8; i++) begin
      cycle(1, i == 8, 8'(i), 10'h010);
      if (i == 4) chk("t1_word0", wr_data_o, 32'h04030201);
    end
    chk("t1_addr1", wr_addr_o, 32'h011);
    chk("t1_word1", wr_data_o, 32'h08070605);
    chk("t1_len", frame_len_o, 32'd8);

    // 6 bytes 11..16 at base 0x040, starts right after previous done
    for (int i = 0; i < 6; i++) cycle(1, i == 5, 8'(8'h11 + i), 10'h040);
    chk("t2_addr", wr_addr_o, 32'h041);
    chk("t2_data", wr_data_o, 32'h00001615);
    chk("t2_strb", wr_strb_o, 32'h3);
    chk("t2_len", frame_len_o, 32'd6);

    cycle(0, 0, 8'h00, 10'h000);
    cycle(1, 1, 8'h7F, 10'h123);
    chk("t3_data", wr_data_o, 32'h0000007F);
    chk("t3_strb", wr_strb_o, 32'h1);
    chk("t3_done", done_o, 32'h1);
    chk("t3_len", frame_len_o, 32'd1);

    cycle(0, 0, 8'h00, 10'h000);
    cycle(1, 0, 8'h80, 10'h050);
    cycle(1, 0, 8'hFF, 10'h000);
    cycle(1, 0, 8'h05, 10'h000);
    cycle(1, 1, 8'h90, 10'h000);
`ifdef FC_PACKER_RELU_EN
    chk("t4_act", wr_data_o, 32'h00050000);
`else
    chk("t4_act", wr_data_o, 32'h9005FF80);
`endif

    // wrap at top of address space, with gaps and stray last_i
    for (int i = 0; i < 8; i++) begin
      int gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) cycle(0, 1'($urandom_range(0, 1)), 8'($urandom), 10'($urandom));
      cycle(1, i == 7, 8'(8'hA0 + i), 10'h3FF);
      if (i == 3) chk("t5_addr0", wr_addr_o, 32'h3FF);
    end
    chk("t5_addr1", wr_addr_o, 32'h000);
    chk("t5_len", frame_len_o, 32'd8);

    // reset mid-frame discards partial word
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'(8'h31 + i), 10'h070);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, i == 3, 8'(8'h41 + i), 10'h020);
    chk("t6_addr", wr_addr_o, 32'h020);
    chk("t6_data", wr_data_o, 32'h44434241);
    chk("t6_len", frame_len_o, 32'd4);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else begin
        bit v = (r < 150);
        bit l = v && (($urandom_range(0, 9) == 0) || (in_frame && cnt >= 127));
        cycle(v, l, 8'($urandom), 10'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_result_packer.md
Name: fc_result_packer

Overview:
- Receiving end of the FC accumulator's activation-side interface: consumes the fc_valid / last / 8-bit result stream and applies activation.
- Packs four consecutive int8 results little-endian into 32-bit words and writes them to the output feature SRAM with byte strobes.
- Flushes any partial word on last and pulses done, which tells the layer controller that the FC output vector is fully stored.
- Input side has no backpressure; the block accepts one byte every cycle indefinitely.

Parameters:
- ADDR_WIDTH, 10, output SRAM word-address width
- WORD_BYTES, 4, bytes per SRAM word (fixed 4; DATA width = 8*WORD_BYTES)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fc_valid_i  in  1  result byte valid this cycle
- last_i  in  1  final byte of the output vector; qualified by fc_valid_i
- fc_result_i  in  8  signed saturated FC result
- base_addr_i  in  ADDR_WIDTH  first word address; sampled on first valid byte of a frame
- wr_en_o  out  1  SRAM write enable, one-cycle pulse per word
- wr_addr_o  out  ADDR_WIDTH  SRAM word address
- wr_data_o  out  32  packed word; byte k = k-th byte of group
- wr_strb_o  out  4  byte-lane enables
- done_o  out  1  one-cycle pulse, coincident with the final write of a frame
- frame_len_o  out  8  bytes in the last completed frame (1..128); held until next done

Behaviour:
- Reset (rst=1 at clock edge): state=S_IDLE, lane=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_strb_o=0, done_o=0, frame_len_o=0. The partial word is discarded and no write is issued.
- States: S_IDLE, S_PACK.
- S_IDLE + fc_valid_i:
  - latch word pointer <= base_addr_i, byte count <= 1
  - byte goes to lane 0
  - go to S_PACK, unless last_i is also set (then flush immediately and stay in S_IDLE)
- S_PACK + fc_valid_i:
  - byte goes to lane `lane`; byte count increments
  - word is complete when lane==3 or last_i
- On word complete, the next cycle drives wr_en_o=1, wr_addr_o=pointer, wr_data_o=assembled word and wr_strb_o with bits [0..lane] set.
  - Latency: exactly 1 cycle from the completing input byte.
  - Pointer increments after each write and wraps modulo 2^ADDR_WIDTH.
  - lane returns to 0.
- Unfilled lanes of a partial word: data 0, strobe 0.
- last_i with fc_valid_i:
  - flush as above
  - done_o=1 in the same cycle as that write
  - frame_len_o <= byte count
  - state -> S_IDLE
- fc_valid_i=0 cycles inside a frame: hold lane and pointer; gaps are allowed.
- last_i without fc_valid_i is ignored.
- Valid byte in the cycle the previous frame's final write and done_o are being driven: accepted as the first byte of a new frame (base re-sampled). Outputs for the old word are unaffected.
- Back-to-back words: wr_en_o may be high every 4th cycle under a continuous stream. The block never drops a byte.
- Activation: byte stored = act(fc_result_i), evaluated combinationally before lane insertion. See the optional feature below.
- wr_en_o, wr_strb_o and done_o return to 0 the cycle after a pulse; wr_data_o and wr_addr_o hold their last values.

Optional Feature:
- Macro FC_PACKER_RELU_EN.
- Defined: act(x) = (x[7]==1) ? 8'h00 : x, i.e. ReLU fused into the packer.
- Undefined: act(x) = x, raw signed pass-through; the activation is applied downstream.
- No port or timing differences between the two builds.

Decomposition:
- Shared package fc_pkg:
  - state enum {S_IDLE, S_PACK}
  - localparams FC_BYTE_W=8, FC_WORD_BYTES=4, FC_MAX_NODES=128
  - function fc_relu(logic signed [7:0]) returning logic [7:0]
- One small combinational sub-module, fc_act_unit: wraps the macro-selected activation so the packer core stays macro-free.

Test Plan:
- base_addr_i=0x010; 8 consecutive valid bytes 01..08, last on 08 -> writes @0x010 data 0x04030201 strb 0xF, @0x011 data 0x08070605 strb 0xF with done_o=1, frame_len_o=8.
- 6 bytes 11..16 with last on 16 -> second write @base+1 data 0x00001615 strb 0x3, done_o=1, frame_len_o=6.
- Single byte 0x7F with valid+last in S_IDLE -> one write data 0x0000007F strb 0x1, done_o=1 next cycle, frame_len_o=1.
- Bytes 0x80,0xFF,0x05,0x90 -> data 0x00050000 with FC_PACKER_RELU_EN defined, 0x9005FF80 without.
- base_addr_i=0x3FF, 8 bytes -> writes @0x3FF then @0x000; random idle gaps between bytes leave the data identical.
- rst pulsed after 3 bytes of a frame -> no write; a new 4-byte frame at base 0x020 writes @0x020 with only the new bytes, frame_len_o=4.
